ex_stage_md: RTL



---
 rtl/core_pkg.sv | 33 +++
 rtl/ex_stage_md_if.sv | 37 +++
 rtl/md_unit.sv | 127 ++++++++++++
 rtl/ex_stage_md.sv | 72 +++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: ALU encodings, RV32M funct3 codes, M-unit FSM states
package core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_type_e;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/ex_stage_md_if.sv
// rtl/ex_stage_md_if.sv - ID/EX payload and EX-stage results bundled between pipeline and execute stage
interface ex_stage_md_if #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int FW      = $clog2(NUM_FWD + 1)
);
   logic                    valid_ex;
   logic                    flush_ex;
   logic                    alu_src1_ex;
   logic                    alu_src2_ex;
   logic [3:0]              alu_type_ex;
   logic                    md_en_ex;
   logic [2:0]              md_op_ex;
   logic [XLEN-1:0]         pc_ex;
   logic [XLEN-1:0]         imm_ex;
   logic [XLEN-1:0]         rs1_data_ex;
   logic [XLEN-1:0]         rs2_data_ex;
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic [FW-1:0]           rs1_fwd_ex;
   logic [FW-1:0]           rs2_fwd_ex;
   logic [XLEN-1:0]         result_ex;
   logic [XLEN-1:0]         real_rs1_data_ex;
   logic [XLEN-1:0]         real_rs2_data_ex;
   logic                    stall_ex;

   modport master (
      output valid_ex, flush_ex, alu_src1_ex, alu_src2_ex, alu_type_ex, md_en_ex, md_op_ex,
             pc_ex, imm_ex, rs1_data_ex, rs2_data_ex, fwd_data, rs1_fwd_ex, rs2_fwd_ex,
      input  result_ex, real_rs1_data_ex, real_rs2_data_ex, stall_ex
   );

   modport slave (
      input  valid_ex, flush_ex, alu_src1_ex, alu_src2_ex, alu_type_ex, md_en_ex, md_op_ex,
             pc_ex, imm_ex, rs1_data_ex, rs2_data_ex, fwd_data, rs1_fwd_ex, rs2_fwd_ex,
      output result_ex, real_rs1_data_ex, real_rs2_data_ex, stall_ex
   );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes
module md_unit
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            idle,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e         state_q, state_d;
   logic [2:0]        op_q;
   logic              a_neg_q, b_neg_q;
   logic [XLEN-1:0]   m_q, lo_q, res_q;
   logic [XLEN:0]     hi_q;
   logic [CW-1:0]     cnt_q;

   logic              is_div, a_signed, b_signed, a_neg, b_neg;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   abs_a, abs_b, special_res;

   always_comb begin
      is_div      = op[2];
      a_signed    = is_div ? ~op[0] : (op != MD_MULHU);
      b_signed    = is_div ? ~op[0] : (op == MD_MUL || op == MD_MULH);
      a_neg       = a_signed & a[XLEN-1];
      b_neg       = b_signed & b[XLEN-1];
      abs_a       = a_neg ? -a : a;
      abs_b       = b_neg ? -b : b;
      div_zero    = is_div & (b == '0);
      div_ovf     = is_div & ~op[0] & (a == MIN_VAL) & (b == '1);
      special     = div_zero | div_ovf;
      // op[1] distinguishes REM/REMU from DIV/DIVU
      if (div_zero) special_res = op[1] ? a : '1;
      else          special_res = op[1] ? '0 : MIN_VAL;
   end

   logic [XLEN:0]     sum, shifted, diff, hi_n;
   logic [XLEN-1:0]   lo_n, quo_s, rem_s, final_res;
   logic [2*XLEN-1:0] prod, prod_s;

   // multiply keeps the multiplier in lo and shifts the partial product in from hi;
   // divide shifts the dividend out of lo and builds the quotient behind it
   always_comb begin
      sum     = lo_q[0] ? hi_q + {1'b0, m_q} : hi_q;
      shifted = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
      diff    = shifted - {1'b0, m_q};
      if (op_q[2]) begin
         if (!diff[XLEN]) begin
            hi_n = diff;
            lo_n = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_n = shifted;
            lo_n = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_n = {1'b0, sum[XLEN:1]};
         lo_n = {sum[0], lo_q[XLEN-1:1]};
      end
      prod   = {hi_n[XLEN-1:0], lo_n};
      prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
      quo_s  = (a_neg_q ^ b_neg_q) ? -lo_n : lo_n;
      rem_s  = a_neg_q ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
      if (op_q[2])              final_res = op_q[1] ? rem_s : quo_s;
      else if (op_q == MD_MUL)  final_res = prod_s[XLEN-1:0];
      else                      final_res = prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = special ? DONE : BUSY;
         BUSY:    if (cnt_q == CW'(XLEN - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
      idle   = (state_q == IDLE);
      busy   = (state_q == BUSY);
      done   = (state_q == DONE);
      result = res_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else if (state_q == IDLE && start && !flush) begin
         op_q    <= op;
         a_neg_q <= a_neg;
         b_neg_q <= b_neg;
         m_q     <= is_div ? abs_b : abs_a;
         lo_q    <= is_div ? abs_a : abs_b;
         hi_q    <= '0;
         cnt_q   <= '0;
         if (special) res_q <= special_res;
      end else if (state_q == BUSY && !flush) begin
         hi_q  <= hi_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CW'(XLEN - 1)) res_q <= final_res;
      end
   end

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage: N-source forwarding, single-cycle ALU, iterative M-unit with stall
module ex_stage_md
   import core_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2,
   parameter int FW      = $clog2(NUM_FWD + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   ex_stage_md_if.slave ex
);
   localparam int SW = $clog2(XLEN);

   // select values beyond NUM_FWD fall back to register-file data
   function automatic logic [XLEN-1:0] fwd_pick(input logic [FW-1:0]           sel,
                                                input logic [XLEN-1:0]         rf,
                                                input logic [NUM_FWD*XLEN-1:0] slots);
      fwd_pick = rf;
      for (int k = 1; k <= NUM_FWD; k++)
         if (int'(sel) == k) fwd_pick = slots[(k-1)*XLEN +: XLEN];
   endfunction

   logic [XLEN-1:0] rs1_real, rs2_real, op1, op2, alu_res, md_res;
   logic [SW-1:0]   shamt;
   logic            md_idle, md_busy, md_done, issue;

   always_comb begin
      rs1_real = fwd_pick(ex.rs1_fwd_ex, ex.rs1_data_ex, ex.fwd_data);
      rs2_real = fwd_pick(ex.rs2_fwd_ex, ex.rs2_data_ex, ex.fwd_data);
      op1      = ex.alu_src1_ex ? ex.pc_ex  : rs1_real;
      op2      = ex.alu_src2_ex ? ex.imm_ex : rs2_real;
      shamt    = op2[SW-1:0];
      case (ex.alu_type_ex)
         ALU_ADD:  alu_res = op1 + op2;
         ALU_SUB:  alu_res = op1 - op2;
         ALU_SLL:  alu_res = op1 << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
         ALU_XOR:  alu_res = op1 ^ op2;
         ALU_SRL:  alu_res = op1 >> shamt;
         ALU_SRA:  alu_res = $signed(op1) >>> shamt;
         ALU_OR:   alu_res = op1 | op2;
         ALU_AND:  alu_res = op1 & op2;
         ALU_LUI:  alu_res = op2;
         default:  alu_res = op1 + op2;
      endcase
   end

   // no issue while reset is held, so stall_ex drops the moment rst_n falls
   assign issue = md_idle & ex.valid_ex & ex.md_en_ex & ~ex.flush_ex & rst_n;

   md_unit #(.XLEN(XLEN)) u_md (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (issue),
      .flush  (ex.flush_ex),
      .op     (ex.md_op_ex),
      .a      (rs1_real),
      .b      (rs2_real),
      .idle   (md_idle),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_res)
   );

   assign ex.real_rs1_data_ex = rs1_real;
   assign ex.real_rs2_data_ex = rs2_real;
   assign ex.stall_ex         = issue | (md_busy & ~ex.flush_ex);
   assign ex.result_ex        = (md_done & ~ex.flush_ex) ? md_res : alu_res;

endmodule
